// File: rtl/vc_credit_tracker.sv
// Per-output-port credit engine: per-VC downstream credit counters plus a
// timestamped return FIFO that releases each credit once its due cycle arrives.
module vc_credit_tracker #(
    parameter int NUM_VC      = 4,
    parameter int VC_W        = 2,
    parameter int CREDIT_INIT = 4,
    parameter int CREDIT_W    = 4,
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter int TS_W        = 16,
    parameter int DELAY_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init,
    input  logic [DELAY_W-1:0]           cfg_delay,
    input  logic [TS_W-1:0]              cycle,
    input  logic                         cr_valid,
    input  logic [VC_W-1:0]              cr_vc,
    input  logic [TS_W-1:0]              cr_ts,
    output logic                         cr_ready,
    input  logic                         use_valid,
    input  logic [VC_W-1:0]              use_vc,
    output logic [NUM_VC-1:0]            credit_avail,
    output logic [NUM_VC*CREDIT_W-1:0]   credit_count,
    output logic                         idle,
    output logic                         ovf_err,
    output logic                         udf_err
);

    logic [CREDIT_W-1:0] r_credit   [NUM_VC];
    logic [VC_W-1:0]     r_fifo_vc  [DEPTH];
    logic [TS_W-1:0]     r_fifo_due [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [PTR_W:0]      r_count;
    logic                r_ovf;
    logic                r_udf;

    logic [CREDIT_W-1:0] w_credit_nxt [NUM_VC];
    logic [NUM_VC-1:0]   w_inc;
    logic [NUM_VC-1:0]   w_dec;
    logic [NUM_VC-1:0]   w_ovf_hit;
    logic [NUM_VC-1:0]   w_udf_hit;
    logic [TS_W-1:0]     w_age;
    logic [VC_W-1:0]     w_pop_vc;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_cr_vc_ok;
    logic                w_use_vc_ok;

    assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_cr_vc_ok  = (int'(cr_vc) < NUM_VC);
    assign w_use_vc_ok = (int'(use_vc) < NUM_VC);
    assign w_push      = cr_valid && !w_full && w_cr_vc_ok;

    // Wrap-safe "cycle >= due": the modular age is non-negative when its MSB is clear.
    assign w_age    = cycle - r_fifo_due[r_head];
    assign w_pop    = (r_count != '0) && (w_age < {1'b1, {(TS_W-1){1'b0}}});
    assign w_pop_vc = r_fifo_vc[r_head];

    always_comb begin
        w_credit_nxt = r_credit;
        w_inc        = '0;
        w_dec        = '0;
        w_ovf_hit    = '0;
        w_udf_hit    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_inc[v] = w_pop && (int'(w_pop_vc) == v);
            w_dec[v] = use_valid && w_use_vc_ok && (int'(use_vc) == v);
            // A release and a consume on the same VC cancel, even from zero credits.
            case ({w_inc[v], w_dec[v]})
                2'b10: begin
                    if (r_credit[v] == CREDIT_W'(CREDIT_INIT))
                        w_ovf_hit[v] = 1'b1;
                    else
                        w_credit_nxt[v] = r_credit[v] + CREDIT_W'(1);
                end
                2'b01: begin
                    if (r_credit[v] == '0)
                        w_udf_hit[v] = 1'b1;
                    else
                        w_credit_nxt[v] = r_credit[v] - CREDIT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= '{default: CREDIT_W'(CREDIT_INIT)};
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (init) begin
            r_credit <= '{default: CREDIT_W'(CREDIT_INIT)};
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: ;
            endcase
            if ((cr_valid && w_full) || (|w_ovf_hit))
                r_ovf <= 1'b1;
            if (|w_udf_hit)
                r_udf <= 1'b1;
        end
    end

    // Entry storage carries no reset; occupancy is governed by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_vc[r_tail]  <= cr_vc;
            r_fifo_due[r_tail] <= cr_ts + TS_W'(cfg_delay);
        end
    end

    for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_out
        assign credit_count[gv*CREDIT_W +: CREDIT_W] = r_credit[gv];
        assign credit_avail[gv]                      = (r_credit[gv] != '0);
    end

    assign cr_ready = !w_full;
    assign idle     = (r_count == '0);
    assign ovf_err  = r_ovf;
    assign udf_err  = r_udf;

endmodule
